dll_alu_ctrl: RTL and testbench

//  Synthesizable delay-control ALU for the DLL family. It is the parametrised successor of the

---
 rtl/dll_pkg.sv | 19 +
 rtl/dll_slave_scale.sv | 19 +
 rtl/dll_alu_ctrl.sv | 153 +++++++++++++++
 tb/tb_dll_alu_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// dll_pkg: shared FSM state type and code helpers for the DLL delay-control ALU.
package dll_pkg;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } dll_state_e;

    function automatic int gray_enc(input int c);
        return c ^ (c >> 1);
    endfunction

    // Clamp a signed value into the unsigned range of a w-bit code.
    function automatic int sat_w(input int v, input int w);
        return (v < 0) ? 0 : (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

endpackage

// File: rtl/dll_slave_scale.sv
// dll_slave_scale: registered slave delay code, code*RATIO/16 clamped to the code range.
module dll_slave_scale
    import dll_pkg::*;
#(
    parameter int CODE_W = 6,
    parameter int RATIO  = 16
) (
    input  logic              CLKI,
    input  logic              RSTN,
    input  logic [CODE_W-1:0] i_code,
    output logic [CODE_W-1:0] o_code
);

    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) o_code <= '0;
        else       o_code <= CODE_W'(sat_w((int'(i_code) * RATIO) >> 4, CODE_W));
    end

endmodule

// File: rtl/dll_alu_ctrl.sv
// dll_alu_ctrl: glitch-filtered saturating delay-code ALU with lock FSM,
// signed user offset and scaled slave code outputs.
module dll_alu_ctrl
    import dll_pkg::*;
#(
    parameter int                      CODE_W           = 6,
    parameter int                      DELVAL_W         = 5,
    parameter int                      NUM_SLAVES       = 2,
    parameter logic [NUM_SLAVES*5-1:0] SLAVE_RATIO      = {5'd8, 5'd16},
    parameter int                      GLITCH_TOLERANCE = 2,
    parameter int                      ALU_LOCK_CNT     = 3,
    parameter int                      ALU_UNLOCK_CNT   = 15,
    parameter int                      LOCK_DELAY       = 100
) (
    input  logic                         CLKI,
    input  logic                         RSTN,
    input  logic                         PD_VALID,
    input  logic                         PD_LEAD,
    input  logic                         ALUHOLD,
    input  logic                         UDDCNTL,
    input  logic                         DELADJPOL,
    input  logic [DELVAL_W-1:0]          DELVAL,
    output logic [CODE_W-1:0]            DCNTL,
    output logic [NUM_SLAVES*CODE_W-1:0] SCNTL,
    output logic [CODE_W-1:0]            GRAYO,
    output logic                         INCO,
    output logic                         DIFF,
    output logic                         LOCK
);

    localparam int RUN_W  = $clog2(GLITCH_TOLERANCE + 1);
    localparam int REV_W  = $clog2(ALU_LOCK_CNT + 1);
    localparam int SAME_W = $clog2(ALU_UNLOCK_CNT + 1);
    localparam int DLY_W  = $clog2(LOCK_DELAY + 1);
    localparam logic [CODE_W-1:0] CODE_MAX = '1;

    logic [CODE_W-1:0] r_code, r_dcntl, r_gray;
    logic              r_last, r_inco, r_stepped, r_diff, r_lock;
    logic [RUN_W-1:0]  r_run;
    logic [REV_W-1:0]  r_rev;
    logic [SAME_W-1:0] r_same;
    logic [DLY_W-1:0]  r_dly;
    dll_state_e        r_state;

    logic [RUN_W-1:0]         w_run_next;
    logic [SAME_W-1:0]        w_same_next;
    logic [CODE_W-1:0]        w_code_next;
    logic signed [CODE_W+1:0] w_adj;
    logic                     w_act, w_step, w_rev, w_same, w_unlock;

    // Run length saturates at the tolerance; only reaching it matters.
    assign w_act       = PD_VALID & ~ALUHOLD;
    assign w_run_next  = (PD_LEAD != r_last) ? RUN_W'(1) :
                         (r_run == RUN_W'(GLITCH_TOLERANCE)) ? r_run : r_run + RUN_W'(1);
    assign w_step      = w_act & (w_run_next >= RUN_W'(GLITCH_TOLERANCE));
    assign w_rev       = w_step & r_stepped & (PD_LEAD != r_inco);
    assign w_same      = w_step & ~w_rev;
    assign w_same_next = w_rev ? '0 : w_same ? r_same + SAME_W'(1) : r_same;
    assign w_unlock    = w_same & (r_same == SAME_W'(ALU_UNLOCK_CNT - 1));
    assign w_code_next = PD_LEAD ? ((r_code == CODE_MAX) ? r_code : r_code + CODE_W'(1))
                                 : ((r_code == '0) ? r_code : r_code - CODE_W'(1));
    assign w_adj       = DELADJPOL ? $signed({2'b00, r_code}) - $signed((CODE_W+2)'(DELVAL))
                                   : $signed({2'b00, r_code}) + $signed((CODE_W+2)'(DELVAL));

    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            r_code    <= '0;
            r_last    <= 1'b0;
            r_run     <= '0;
            r_inco    <= 1'b0;
            r_stepped <= 1'b0;
            r_diff    <= 1'b0;
        end else begin
            r_diff <= w_rev;
            if (w_act) begin
                r_last <= PD_LEAD;
                r_run  <= w_run_next;
            end
            if (w_step) begin
                r_code    <= w_code_next;
                r_inco    <= PD_LEAD;
                r_stepped <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ACQ;
            r_rev   <= '0;
            r_same  <= '0;
            r_dly   <= '0;
            r_lock  <= 1'b0;
        end else begin
            r_lock <= (r_state == LOCKED);
            case (r_state)
                ACQ: begin
                    if (w_rev && r_rev == REV_W'(ALU_LOCK_CNT - 1)) begin
                        r_state <= SETTLE;
                        r_rev   <= '0;
                        r_same  <= '0;
                        r_dly   <= '0;
                    end else if (w_rev) r_rev <= r_rev + REV_W'(1);
                    else if (w_same)    r_rev <= '0;
                end
                SETTLE, LOCKED: begin
                    if (w_unlock) begin
                        r_state <= ACQ;
                        r_same  <= '0;
                        r_dly   <= '0;
                    end else begin
                        r_same <= w_same_next;
                        // The settle timer pauses while the ALU is held.
                        if (r_state == SETTLE && !ALUHOLD) begin
                            if (r_dly == DLY_W'(LOCK_DELAY - 1)) r_state <= LOCKED;
                            else                                 r_dly   <= r_dly + DLY_W'(1);
                        end
                    end
                end
                default: r_state <= ACQ;
            endcase
        end
    end

    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            r_dcntl <= '0;
            r_gray  <= '0;
        end else begin
            if (UDDCNTL) r_dcntl <= CODE_W'(sat_w(int'(w_adj), CODE_W));
            r_gray <= CODE_W'(gray_enc(int'(r_code)));
        end
    end

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_slave
        dll_slave_scale #(
            .CODE_W (CODE_W),
            .RATIO  (int'(SLAVE_RATIO[k*5 +: 5]))
        ) u_scale (
            .CLKI   (CLKI),
            .RSTN   (RSTN),
            .i_code (r_dcntl),
            .o_code (SCNTL[k*CODE_W +: CODE_W])
        );
    end

    assign DCNTL = r_dcntl;
    assign GRAYO = r_gray;
    assign INCO  = r_inco;
    assign DIFF  = r_diff;
    assign LOCK  = r_lock;

endmodule

// File: tb/tb_dll_alu_ctrl.sv
// tb_dll_alu_ctrl: directed checks of the DLL ALU on a GT=1 instance and a GT=2 instance.
module tb_dll_alu_ctrl;

    logic        CLKI = 1'b0;
    logic        RSTN = 1'b0;
    logic        PD_VALID = 1'b0;
    logic        PD_LEAD = 1'b0;
    logic        ALUHOLD = 1'b0;
    logic        UDDCNTL = 1'b1;
    logic        DELADJPOL = 1'b0;
    logic [4:0]  DELVAL = '0;

    logic [5:0]  dcntl, grayo, dcntl2, grayo2;
    logic [11:0] scntl, scntl2;
    logic        inco, diff, lock, inco2, diff2, lock2;

    int n_total = 0;
    int n_bad = 0;

    always #5 CLKI = ~CLKI;

    dll_alu_ctrl #(.GLITCH_TOLERANCE(1)) u_dut (
        .CLKI(CLKI), .RSTN(RSTN), .PD_VALID(PD_VALID), .PD_LEAD(PD_LEAD),
        .ALUHOLD(ALUHOLD), .UDDCNTL(UDDCNTL), .DELADJPOL(DELADJPOL), .DELVAL(DELVAL),
        .DCNTL(dcntl), .SCNTL(scntl), .GRAYO(grayo), .INCO(inco), .DIFF(diff), .LOCK(lock)
    );

    dll_alu_ctrl #(.GLITCH_TOLERANCE(2)) u_gt2 (
        .CLKI(CLKI), .RSTN(RSTN), .PD_VALID(PD_VALID), .PD_LEAD(PD_LEAD),
        .ALUHOLD(ALUHOLD), .UDDCNTL(UDDCNTL), .DELADJPOL(DELADJPOL), .DELVAL(DELVAL),
        .DCNTL(dcntl2), .SCNTL(scntl2), .GRAYO(grayo2), .INCO(inco2), .DIFF(diff2), .LOCK(lock2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLKI);
            #1;
        end
    endtask

    task automatic samples(input logic lead, input int n);
        repeat (n) begin
            PD_VALID = 1'b1;
            PD_LEAD  = lead;
            tick(1);
            PD_VALID = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(2);
        chk("rst_dcntl", dcntl, 0);
        chk("rst_scntl", scntl, 0);
        chk("rst_gray", grayo, 0);
        chk("rst_inco", inco, 0);
        chk("rst_diff", diff, 0);
        chk("rst_lock", lock, 0);
        chk("rst_gt2", {scntl2, dcntl2, grayo2, inco2, diff2, lock2}, 0);
        RSTN = 1'b1;
        tick(1);

        // 1: GT=2 needs a run of two before stepping; 10 leads give 9 steps.
        samples(1'b1, 10);
        tick(1);
        chk("t1_dcntl", dcntl2, 9);
        chk("t1_gray", grayo2, 6'b001101);
        chk("t1_inco", inco2, 1);
        chk("t1_lock", lock2, 0);
        chk("t1_gt1_dcntl", dcntl, 10);
        samples(1'b0, 1);
        samples(1'b1, 1);
        tick(1);
        chk("t1_glitch", dcntl2, 9);
        chk("t1_gt1_glitch", dcntl, 10);

        // 2: up saturation and upper offset clamp.
        samples(1'b1, 52);
        tick(1);
        chk("t2_62", dcntl, 62);
        samples(1'b1, 5);
        tick(1);
        chk("t2_sat", dcntl, 63);
        chk("t2_inco", inco, 1);
        chk("t2_gray", grayo, 6'b100000);
        DELVAL = 5'd5;
        tick(2);
        chk("t2_clamp_hi", dcntl, 63);
        chk("t2_s0", scntl[5:0], 63);
        chk("t2_s1", scntl[11:6], 31);
        DELVAL = 5'd0;
        tick(1);

        // 3: three reversals enter SETTLE; LOCK after LOCK_DELAY+1 cycles.
        samples(1'b0, 1);
        chk("t3_diff", diff, 1);
        chk("t3_inco", inco, 0);
        tick(1);
        chk("t3_diff_pulse", diff, 0);
        samples(1'b1, 1);
        samples(1'b0, 1);
        tick(100);
        chk("t3_lock_early", lock, 0);
        tick(1);
        chk("t3_lock", lock, 1);

        // 4: unlock only after 15 same-direction steps.
        samples(1'b0, 14);
        tick(3);
        chk("t4_lock14", lock, 1);
        samples(1'b1, 1);
        samples(1'b0, 1);
        samples(1'b0, 14);
        chk("t4_lock14b", lock, 1);
        samples(1'b0, 1);
        chk("t4_lock_15th", lock, 1);
        tick(1);
        chk("t4_unlock", lock, 0);
        chk("t4_code", dcntl, 33);

        // 5: offset clamps, slave scaling, UDDCNTL freeze.
        samples(1'b0, 29);
        DELVAL    = 5'd6;
        DELADJPOL = 1'b1;
        tick(2);
        chk("t5_sub", dcntl, 0);
        chk("t5_sub_s1", scntl[11:6], 0);
        DELADJPOL = 1'b0;
        tick(1);
        chk("t5_add", dcntl, 10);
        tick(1);
        chk("t5_s1", scntl[11:6], 5);
        chk("t5_s0", scntl[5:0], 10);
        UDDCNTL = 1'b0;
        samples(1'b1, 3);
        tick(1);
        chk("t5_frozen", dcntl, 10);
        chk("t5_gray", grayo, 4);
        UDDCNTL = 1'b1;
        tick(1);
        chk("t5_track", dcntl, 13);
        DELVAL = 5'd0;
        tick(1);
        chk("t5_nooff", dcntl, 7);

        // 6: ALUHOLD pauses settle timer and code; async reset clears outputs.
        samples(1'b0, 1);
        samples(1'b1, 1);
        samples(1'b0, 1);
        tick(40);
        ALUHOLD = 1'b1;
        tick(10);
        samples(1'b1, 1);
        tick(39);
        chk("t6_hold_code", dcntl, 6);
        chk("t6_hold_inco", inco, 0);
        chk("t6_hold_lock", lock, 0);
        ALUHOLD = 1'b0;
        tick(60);
        chk("t6_lock_early", lock, 0);
        tick(1);
        chk("t6_lock", lock, 1);
        tick(2);
        RSTN = 1'b0;
        #1;
        chk("t6_rst_dcntl", dcntl, 0);
        chk("t6_rst_scntl", scntl, 0);
        chk("t6_rst_gray", grayo, 0);
        chk("t6_rst_lock", lock, 0);
        chk("t6_rst_inco", inco, 0);
        RSTN = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
